// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: state encoding, reset/halt defaults, NOP.
package fetch_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEF_HALT_WORD = 32'h0000_000C;
   localparam logic [31:0] NOP_WORD      = 32'h0000_0000;
   localparam int unsigned DEF_CNT_W     = 32;

endpackage : fetch_pkg

// File: rtl/next_pc_sel.sv
// Combinational redirect target computation and next-PC priority mux.
module next_pc_sel (
   input  logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [15:0] branch_offset,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        jump_reg,
   input  logic [31:0] reg_target,
   output logic [31:0] next_pc
);

   logic [31:0] w_br_tgt;
   logic [31:0] w_j_tgt;

   assign w_br_tgt = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};
   assign w_j_tgt  = {pc_plus4[31:28], jump_target, 2'b00};

   // Priority: register jump over direct jump over taken branch over sequential
   always_comb begin
      next_pc = pc_plus4;
      if (jump_reg)
         next_pc = reg_target;
      else if (jump)
         next_pc = w_j_tgt;
      else if (branch_taken)
         next_pc = w_br_tgt;
   end

endmodule : next_pc_sel

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, run/halt/fault state and retired-instruction counter.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [31:0] HALT_WORD = DEF_HALT_WORD,
   parameter int unsigned CNT_W     = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_offset,
   input  logic             jump,
   input  logic [25:0]      jump_target,
   input  logic             jump_reg,
   input  logic [31:0]      reg_target,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_data,
   output logic [31:0]      instr,
   output logic [31:0]      pc_plus4,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] retired_count
);

   logic [31:0]      r_pc;
   fetch_state_t     r_state;
   logic [CNT_W-1:0] r_count;

   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_next_pc;
   logic [31:0]      w_instr;
   logic             w_run;
   logic             w_misaligned;

   assign w_run        = (r_state == ST_RUN);
   assign w_pc_plus4   = r_pc + 32'd4;
   assign w_instr      = w_run ? imem_data : NOP_WORD;
   assign w_misaligned = jump_reg && (reg_target[1:0] != 2'b00);

   next_pc_sel u_next_pc_sel (
      .pc_plus4      (w_pc_plus4),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .jump_reg      (jump_reg),
      .reg_target    (reg_target),
      .next_pc       (w_next_pc)
   );

   // PC, state and saturating retire counter; halt word beats faults and redirects
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_state <= ST_RUN;
         r_count <= '0;
      end else if (w_run && !stall) begin
         if (w_instr == HALT_WORD) begin
            r_state <= ST_HALT;
            if (r_count != '1)
               r_count <= r_count + CNT_W'(1);
         end else if (w_misaligned) begin
            r_state <= ST_FAULT;
         end else begin
            r_pc <= w_next_pc;
            if (r_count != '1)
               r_count <= r_count + CNT_W'(1);
         end
      end
   end

   assign imem_addr     = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign instr         = w_instr;
   assign halted        = (r_state == ST_HALT);
   assign fault         = (r_state == ST_FAULT);
   assign retired_count = r_count;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed and randomized checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [15:0] branch_offset = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_target = '0;
   logic        jump_reg = 1'b0;
   logic [31:0] reg_target = '0;
   logic [31:0] imem_addr, imem_data, instr, pc_plus4;
   logic        halted, fault;
   logic [31:0] retired_count;

   logic [31:0] s_imem_addr, s_instr, s_pc_plus4;
   logic        s_halted, s_fault;
   logic [2:0]  s_retired_count;

   logic [31:0] halt_addr = 32'hFFFF_FFF0;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [31:0] m_pc;
   int unsigned m_cnt;
   bit          m_halt, m_fault;

   always #5 clk = ~clk;

   // Instruction memory: one halt word at halt_addr, distinct non-halt words elsewhere
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == halt_addr) return 32'h0000_000C;
      return 32'h2000_0000 | (a >> 2);
   endfunction

   assign imem_data = mem_word(imem_addr);

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .jump_reg(jump_reg), .reg_target(reg_target), .imem_addr(imem_addr),
      .imem_data(imem_data), .instr(instr), .pc_plus4(pc_plus4),
      .halted(halted), .fault(fault), .retired_count(retired_count)
   );

   // Narrow-counter copy that sees the same stream, to reach saturation
   pc_fetch_unit #(.CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
      .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
      .jump_reg(jump_reg), .reg_target(reg_target), .imem_addr(s_imem_addr),
      .imem_data(imem_data), .instr(s_instr), .pc_plus4(s_pc_plus4),
      .halted(s_halted), .fault(s_fault), .retired_count(s_retired_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] exp_instr;
      exp_instr = (m_halt || m_fault) ? 32'h0 : mem_word(m_pc);
      chk({tag, ":addr"},   imem_addr, m_pc);
      chk({tag, ":pc4"},    pc_plus4, m_pc + 32'd4);
      chk({tag, ":instr"},  instr, exp_instr);
      chk({tag, ":halted"}, 32'(halted), 32'(m_halt));
      chk({tag, ":fault"},  32'(fault), 32'(m_fault));
      chk({tag, ":cnt"},    retired_count, m_cnt);
      chk({tag, ":scnt"},   32'(s_retired_count), (m_cnt > 7) ? 32'd7 : m_cnt);
      chk({tag, ":saddr"},  s_imem_addr, m_pc);
   endtask

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; branch_offset = '0; jump = 0;
      jump_target = '0; jump_reg = 0; reg_target = '0;
   endtask

   // Model of one clock edge from the current inputs
   task automatic model_edge();
      logic [31:0] nxt;
      if (m_halt || m_fault || stall) return;
      if (mem_word(m_pc) == 32'h0000_000C) begin
         m_halt = 1; m_cnt++;
      end else if (jump_reg && (reg_target % 4 != 0)) begin
         m_fault = 1;
      end else begin
         if (jump_reg)          nxt = reg_target;
         else if (jump)         nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jump_target) * 4);
         else if (branch_taken) nxt = m_pc + 32'd4 + 32'($signed(branch_offset)) * 4;
         else                   nxt = m_pc + 32'd4;
         m_pc = nxt; m_cnt++;
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk); #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1; #2;
      m_pc = 32'h0; m_cnt = 0; m_halt = 0; m_fault = 0;
      chk("rst_async_addr", imem_addr, 32'h0);
      @(posedge clk); #1;
      rst = 0;
      check_all("reset");
   endtask

   initial begin
      m_pc = 0; m_cnt = 0; m_halt = 0; m_fault = 0;
      @(posedge clk); #1;
      do_reset();

      // Free run from reset
      for (int i = 0; i < 3; i++) step("freerun");

      // Branches backward then forward
      do_reset();
      step("br_pre0"); step("br_pre1");
      branch_taken = 1; branch_offset = 16'hFFFE; step("br_back");
      chk("br_back_pc", imem_addr, 32'h4);
      branch_offset = 16'h0003; step("br_fwd");
      chk("br_fwd_pc", imem_addr, 32'h14);

      // Priority and jump
      idle_inputs(); jump_reg = 1; reg_target = 32'h1000_0010; step("jr_set");
      jump_reg = 1; jump = 1; branch_taken = 1; reg_target = 32'h40;
      jump_target = 26'h3FF_FFFF; branch_offset = 16'h0100; step("prio");
      chk("prio_pc", imem_addr, 32'h40);
      idle_inputs(); jump_reg = 1; reg_target = 32'h1000_0010; step("jr_set2");
      idle_inputs(); jump = 1; jump_target = 26'h000010; step("jump");
      chk("jump_pc", imem_addr, 32'h1000_0040);

      // Wraparound of pc + 4
      idle_inputs(); jump_reg = 1; reg_target = 32'hFFFF_FFFC; step("wrap_set");
      idle_inputs(); step("wrap");

      // Stall holds then releases into the branch
      do_reset();
      for (int i = 0; i < 3; i++) step("st_pre");
      stall = 1; branch_taken = 1; branch_offset = 16'h0004;
      for (int i = 0; i < 3; i++) step("stall");
      stall = 0; step("st_rel");
      chk("st_rel_pc", imem_addr, 32'h20);

      // Halt wins over jump; terminal until async reset
      halt_addr = 32'h8;
      do_reset();
      step("h_pre0"); step("h_pre1");
      jump = 1; jump_target = 26'h100; step("halt");
      chk("halt_cnt", retired_count, 32'd3);
      jump_reg = 1; reg_target = 32'h3; branch_taken = 1;
      for (int i = 0; i < 3; i++) step("halt_hold");
      #3; rst = 1; #1;
      chk("halt_rst_addr", imem_addr, 32'h0);
      chk("halt_rst_halted", 32'(halted), 32'h0);
      rst = 0;
      halt_addr = 32'hFFFF_FFF0;
      do_reset();

      // Misaligned register target faults
      step("f_pre");
      jump_reg = 1; reg_target = 32'h0000_0042; step("fault");
      idle_inputs();
      for (int i = 0; i < 2; i++) step("fault_hold");

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ((m_halt || m_fault) && ($urandom % 3 == 0)) do_reset();
         if ($urandom % 20 == 0) halt_addr = m_pc;
         stall         = ($urandom % 5 == 0);
         branch_taken  = ($urandom % 2 == 0);
         branch_offset = 16'($urandom);
         jump          = ($urandom % 4 == 0);
         jump_target   = 26'($urandom);
         jump_reg      = ($urandom % 5 == 0);
         reg_target    = $urandom & (($urandom % 4 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         step("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_pc_fetch_unit

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Fetch stage of the single-cycle MIPS core, directly upstream of the instruction memory. It holds the program counter and drives the word address into instruction memory. It passes the returned word to decode and selects the next PC from sequential, branch, jump and jump-register sources. It also tracks run/halt/fault state and counts retired instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
HALT_WORD, 32'h0000_000C, instruction encoding (syscall) that halts fetch.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
stall  in  1  hold PC, state and counter this cycle
branch_taken  in  1  conditional branch resolved taken
branch_offset  in  16  signed word offset (instruction imm field)
jump  in  1  J/JAL redirect
jump_target  in  26  instr_index field
jump_reg  in  1  JR/JALR redirect
reg_target  in  32  register target address
imem_addr  out  32  byte address to instruction memory (equals pc)
imem_data  in  32  instruction word returned combinationally by memory
instr  out  32  instruction to decode
pc_plus4  out  32  pc + 4, for link and branch base
halted  out  1  state == HALT
fault  out  1  state == FAULT
retired_count  out  CNT_W  instructions committed since reset

Behaviour:
- State register values: RUN, HALT, FAULT. Async reset forces pc=RESET_PC, state=RUN, retired_count=0. This is legal mid-operation and takes effect immediately, without waiting for a clock edge.
- Combinational outputs: imem_addr = pc; pc_plus4 = pc + 32'd4 (wraps 0xFFFF_FFFC -> 0x0000_0000).
- instr = imem_data in RUN, 32'h0000_0000 (NOP) in HALT/FAULT. halted and fault decode state directly.
- Targets, all 32-bit with wraparound:
  - br_tgt = pc_plus4 + ({{14{off[15]}}, off, 2'b00})
  - j_tgt = {pc_plus4[31:28], jump_target, 2'b00}
  - jr_tgt = reg_target
- Next-PC priority, applied only in RUN with stall=0: jump_reg > jump > branch_taken > pc_plus4.
- RUN, stall=1: pc, state and counter hold. The halt word and redirects are ignored that cycle.
- RUN, stall=0, instr == HALT_WORD:
  - state -> HALT; pc holds at the halt instruction address.
  - counter += 1.
  - All redirects are ignored (halt wins).
- RUN, stall=0, jump_reg=1 and reg_target[1:0] != 0:
  - state -> FAULT; pc holds.
  - Counter not incremented.
- RUN, stall=0, otherwise: pc <= selected next PC; counter += 1.
- Counter saturates at all-ones; it never wraps.
- HALT and FAULT are terminal until reset. All inputs are ignored; pc and counter hold.
- Misaligned branch/jump targets cannot occur, because their low two bits are structurally 00.
- Latency: redirect inputs sampled at edge N appear on imem_addr after edge N. There are no bubbles and no delay slot.
- Memory index: imem_addr is a byte address. Memory indexes words with addr[31:2], so the pc low bits are always 00 when outside reset.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_HALT=2'd1, ST_FAULT=2'd2
  - default HALT_WORD / RESET_PC constants
  - NOP constant
- One sub-module, next_pc_sel: purely combinational target computation and priority mux. The parent owns all registers and the FSM.

Test Plan:
- Reset then free-run: rst pulse, memory holds non-halt words, stall=0 for 4 cycles -> imem_addr 0x0,0x4,0x8,0xC; retired_count 0,1,2,3; halted=0.
- Branch: pc=0x8, branch_taken=1, branch_offset=16'hFFFE -> next pc=0x4. Then branch_offset=16'h0003 at pc=0x4 -> next pc=0x14.
- Priority/jump: at pc=0x1000_0010 assert jump_reg, jump and branch_taken together with reg_target=0x40 -> next pc=0x40. Then jump alone with jump_target=26'h000010 at that pc -> next pc=0x0000_0040.
- Stall: stall=1 for 3 cycles at pc=0xC with branch_taken=1 -> pc stays 0xC and count unchanged. Release with branch_taken still 1 -> pc follows branch on the next edge.
- Halt: memory word at 0x8 = 32'h0000_000C, jump=1 asserted the same cycle -> pc stays 0x8, halted=1, instr=0, count=3. Further inputs change nothing. Async rst mid-HALT -> pc=0x0, halted=0 immediately.
- Fault: jump_reg=1, reg_target=0x0000_0042 -> fault=1, pc unchanged, count unchanged, instr=0.
